// File: rtl/o_serdes_tx_pkg.sv
// Shared constants and helpers for the o_serdes_tx output serializer.
package o_serdes_tx_pkg;

  // Legal DATA_RATE parameter values.
  localparam string DATA_RATE_SDR = "SDR";
  localparam string DATA_RATE_DDR = "DDR";

  // Legal word-width range.
  localparam int unsigned WIDTH_MIN = 3;
  localparam int unsigned WIDTH_MAX = 10;

  // Counter width sized for the widest legal word.
  localparam int unsigned CNT_W = $clog2(WIDTH_MAX + 1);

  // Number of serial bits emitted per PLL_CLK cycle for a given data rate.
  function automatic int unsigned bits_per_cycle(input string data_rate);
    return (data_rate == DATA_RATE_DDR) ? 32'd2 : 32'd1;
  endfunction

endpackage

// File: rtl/o_serdes_shreg.sv
// Shift register and bit counter for the serializer: parallel load, left
// shift by STEP bits per cycle with zero fill, and a synchronous clear.
module o_serdes_shreg
  import o_serdes_tx_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic             msb_hi,
  output logic             msb_lo
);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next-state: clear beats load, load beats shift; an exhausted word holds zeros.
  always_comb begin
    shreg_d = shreg_q;
    count_d = count_q;
    if (clear) begin
      shreg_d = '0;
      count_d = '0;
    end else if (load) begin
      shreg_d = d;
      count_d = CNT_W'(WIDTH);
    end else if (count_q != '0) begin
      shreg_d = shreg_q << STEP;
      count_d = (count_q > CNT_W'(STEP)) ? (count_q - CNT_W'(STEP)) : '0;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      count_q <= '0;
    end else begin
      shreg_q <= shreg_d;
      count_q <= count_d;
    end
  end

  assign msb_hi = shreg_q[WIDTH-1];
  assign msb_lo = shreg_q[WIDTH-2];

endmodule

// File: rtl/o_serdes_tx.sv
// Parallel-to-serial output serializer (SDR or DDR) with output-enable
// tracking and channel-bonding sync forwarding.
module o_serdes_tx
  import o_serdes_tx_pkg::*;
#(
  parameter string       DATA_RATE = "SDR",
  parameter int unsigned WIDTH     = 4
) (
  input  logic             PLL_CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic             LOAD_WORD,
  input  logic             OE_IN,
  output logic             OE_OUT,
  output logic             Q,
  input  logic             CHANNEL_BOND_SYNC_IN,
  output logic             CHANNEL_BOND_SYNC_OUT,
  input  logic             PLL_LOCK
);

  localparam int unsigned STEP = bits_per_cycle(DATA_RATE);

  if ((DATA_RATE != DATA_RATE_SDR) && (DATA_RATE != DATA_RATE_DDR)) begin : g_bad_rate
    $error("o_serdes_tx: DATA_RATE must be \"SDR\" or \"DDR\"");
  end
  if ((WIDTH < WIDTH_MIN) || (WIDTH > WIDTH_MAX)) begin : g_bad_width
    $error("o_serdes_tx: WIDTH out of range 3..10");
  end
  if ((STEP == 2) && ((WIDTH % 2) != 0)) begin : g_odd_ddr
    $error("o_serdes_tx: WIDTH must be even for DDR");
  end

  logic load_ok;
  logic oe_q, oe_d;
  logic sync_q, sync_d;
  logic msb_hi, msb_lo;
  logic sel_hi;

  // Load is honoured only with the PLL locked and the bonding master in sync.
  always_comb begin
    load_ok = LOAD_WORD & PLL_LOCK & CHANNEL_BOND_SYNC_IN;
  end

  // OE tracks the word: updated only on load edges, cleared while unlocked.
  always_comb begin
    oe_d   = oe_q;
    sync_d = CHANNEL_BOND_SYNC_IN;
    if (!PLL_LOCK) begin
      oe_d = 1'b0;
    end else if (load_ok) begin
      oe_d = OE_IN;
    end
  end

  // OE and bonding-sync registers.
  always_ff @(posedge PLL_CLK) begin
    if (RST) begin
      oe_q   <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      oe_q   <= oe_d;
      sync_q <= sync_d;
    end
  end

  o_serdes_shreg #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_shreg (
    .clk    (PLL_CLK),
    .rst    (RST),
    .clear  (~PLL_LOCK),
    .load   (load_ok),
    .d      (D),
    .msb_hi (msb_hi),
    .msb_lo (msb_lo)
  );

  // Output mux: SDR always presents the MSB; DDR presents the MSB during the
  // high clock phase and the next bit during the low phase.
  always_comb begin
    sel_hi = (STEP == 1) | PLL_CLK;
    Q      = sel_hi ? msb_hi : msb_lo;
  end

  assign OE_OUT                = oe_q;
  assign CHANNEL_BOND_SYNC_OUT = sync_q;

endmodule

// File: tb/tb_o_serdes_tx.sv
// Self-checking bench for o_serdes_tx: SDR and DDR instances, WIDTH=4.
module tb_o_serdes_tx;

  typedef struct {
    logic q;
    logic oe;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] d;
  logic       load_word;
  logic       oe_in;
  logic       sync_in;
  logic       pll_lock;

  logic q_sdr, oe_sdr, sync_sdr;
  logic q_ddr, oe_ddr, sync_ddr;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  o_serdes_tx #(
    .DATA_RATE ("SDR"),
    .WIDTH     (4)
  ) dut_sdr (
    .PLL_CLK               (clk),
    .RST                   (rst),
    .D                     (d),
    .LOAD_WORD             (load_word),
    .OE_IN                 (oe_in),
    .OE_OUT                (oe_sdr),
    .Q                     (q_sdr),
    .CHANNEL_BOND_SYNC_IN  (sync_in),
    .CHANNEL_BOND_SYNC_OUT (sync_sdr),
    .PLL_LOCK              (pll_lock)
  );

  o_serdes_tx #(
    .DATA_RATE ("DDR"),
    .WIDTH     (4)
  ) dut_ddr (
    .PLL_CLK               (clk),
    .RST                   (rst),
    .D                     (d),
    .LOAD_WORD             (load_word),
    .OE_IN                 (oe_in),
    .OE_OUT                (oe_ddr),
    .Q                     (q_ddr),
    .CHANNEL_BOND_SYNC_IN  (sync_in),
    .CHANNEL_BOND_SYNC_OUT (sync_ddr),
    .PLL_LOCK              (pll_lock)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_word(input logic [3:0] w, input logic oe);
    for (int i = 3; i >= 0; i--) sb.push_back('{q: w[i], oe: oe});
  endtask

  task automatic test_reset();
    rst = 1'b1; load_word = 1'b1; d = 4'b1111; oe_in = 1'b1;
    sync_in = 1'b1; pll_lock = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++;
      if (q_sdr !== 1'b0) begin
        n_fail++; $display("FAIL reset_q cyc%0d: got %b want 0", c, q_sdr);
      end
      n_cmp++;
      if (oe_sdr !== 1'b0) begin
        n_fail++; $display("FAIL reset_oe cyc%0d: got %b want 0", c, oe_sdr);
      end
      n_cmp++;
      if (sync_sdr !== 1'b0) begin
        n_fail++; $display("FAIL reset_sync cyc%0d: got %b want 0", c, sync_sdr);
      end
    end
    rst = 1'b0; load_word = 1'b0;
    tick();
  endtask

  task automatic test_sdr_basic();
    exp_t e;
    d = 4'b0101; oe_in = 1'b1; load_word = 1'b1;
    push_word(4'b0101, 1'b1);
    sb.push_back('{q: 1'b0, oe: 1'b1});
    sb.push_back('{q: 1'b0, oe: 1'b1});
    tick();
    load_word = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (q_sdr !== e.q || oe_sdr !== e.oe) begin
        n_fail++;
        $display("FAIL sdr_basic: got q=%b oe=%b want q=%b oe=%b", q_sdr, oe_sdr, e.q, e.oe);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   i = 0;
    d = 4'b1100; oe_in = 1'b1; load_word = 1'b1;
    push_word(4'b1100, 1'b1);
    push_word(4'b0011, 1'b0);
    sb.push_back('{q: 1'b0, oe: 1'b0});
    sb.push_back('{q: 1'b0, oe: 1'b0});
    tick();
    load_word = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (q_sdr !== e.q || oe_sdr !== e.oe) begin
        n_fail++;
        $display("FAIL back_to_back bit%0d: got q=%b oe=%b want q=%b oe=%b",
                 i, q_sdr, oe_sdr, e.q, e.oe);
      end
      if (i == 3) begin
        d = 4'b0011; oe_in = 1'b0; load_word = 1'b1;
      end else begin
        load_word = 1'b0;
      end
      tick();
      i++;
    end
  endtask

  task automatic test_gating();
    exp_t e;
    // Bonding sync low: load must be ignored.
    sync_in = 1'b0; d = 4'b1111; oe_in = 1'b1; load_word = 1'b1;
    for (int c = 0; c < 3; c++) sb.push_back('{q: 1'b0, oe: 1'b0});
    tick();
    load_word = 1'b0;
    n_cmp++;
    if (sync_sdr !== 1'b0) begin
      n_fail++; $display("FAIL sync_follow_low: got %b want 0", sync_sdr);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (q_sdr !== e.q || oe_sdr !== e.oe) begin
        n_fail++;
        $display("FAIL sync_gate: got q=%b oe=%b want q=%b oe=%b", q_sdr, oe_sdr, e.q, e.oe);
      end
      if (sb.size() > 0) tick();
    end
    sync_in = 1'b1;
    #1;
    n_cmp++;
    if (sync_sdr !== 1'b0) begin
      n_fail++; $display("FAIL sync_latency: got %b want 0 before edge", sync_sdr);
    end
    tick();
    n_cmp++;
    if (sync_sdr !== 1'b1) begin
      n_fail++; $display("FAIL sync_follow_high: got %b want 1", sync_sdr);
    end

    // PLL lock lost mid-word: next cycle Q=0 and OE_OUT=0; loads ignored.
    d = 4'b1011; oe_in = 1'b1; load_word = 1'b1;
    sb.push_back('{q: 1'b1, oe: 1'b1});
    sb.push_back('{q: 1'b0, oe: 1'b1});
    sb.push_back('{q: 1'b0, oe: 1'b0});
    sb.push_back('{q: 1'b0, oe: 1'b0});
    tick();
    load_word = 1'b0;
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front();
      n_cmp++;
      if (q_sdr !== e.q || oe_sdr !== e.oe) begin
        n_fail++;
        $display("FAIL pll_lock step%0d: got q=%b oe=%b want q=%b oe=%b",
                 i, q_sdr, oe_sdr, e.q, e.oe);
      end
      if (i == 1) pll_lock = 1'b0;
      if (i == 2) load_word = 1'b1;
      tick();
    end
    load_word = 1'b0;
    pll_lock  = 1'b1;
    tick();
  endtask

  task automatic test_ddr();
    exp_t e;
    d = 4'b1001; oe_in = 1'b1; load_word = 1'b1;
    sb.push_back('{q: 1'b1, oe: 1'b1});
    sb.push_back('{q: 1'b0, oe: 1'b1});
    sb.push_back('{q: 1'b0, oe: 1'b1});
    sb.push_back('{q: 1'b1, oe: 1'b1});
    sb.push_back('{q: 1'b0, oe: 1'b1});
    sb.push_back('{q: 1'b0, oe: 1'b1});
    tick();
    load_word = 1'b0;
    for (int i = 0; sb.size() > 0; i++) begin
      if (i > 0) begin
        if ((i % 2) == 1) begin
          @(negedge clk); #2;
        end else begin
          @(posedge clk); #2;
        end
      end
      e = sb.pop_front();
      n_cmp++;
      if (q_ddr !== e.q || oe_ddr !== e.oe) begin
        n_fail++;
        $display("FAIL ddr half%0d (%s): got q=%b oe=%b want q=%b oe=%b",
                 i, ((i % 2) == 0) ? "high" : "low", q_ddr, oe_ddr, e.q, e.oe);
      end
    end
    tick();
  endtask

  task automatic test_early_reload();
    exp_t e;
    d = 4'b1010; oe_in = 1'b1; load_word = 1'b1;
    sb.push_back('{q: 1'b1, oe: 1'b1});
    sb.push_back('{q: 1'b0, oe: 1'b1});
    push_word(4'b0111, 1'b1);
    sb.push_back('{q: 1'b0, oe: 1'b1});
    tick();
    load_word = 1'b0;
    for (int i = 0; sb.size() > 0; i++) begin
      e = sb.pop_front();
      n_cmp++;
      if (q_sdr !== e.q || oe_sdr !== e.oe) begin
        n_fail++;
        $display("FAIL early_reload bit%0d: got q=%b oe=%b want q=%b oe=%b",
                 i, q_sdr, oe_sdr, e.q, e.oe);
      end
      if (i == 1) begin
        d = 4'b0111; load_word = 1'b1;
      end else begin
        load_word = 1'b0;
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; d = '0; load_word = 1'b0; oe_in = 1'b0;
    sync_in = 1'b1; pll_lock = 1'b1;
    test_reset();
    test_sdr_basic();
    test_back_to_back();
    test_gating();
    test_ddr();
    test_early_reload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
